// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered 4-digit multiplexed common-anode 7-segment driver with valid/ready input
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din_x,
  input  logic [3:0] din_y,
  input  logic [3:0] din_z,
  input  logic [1:0] din_pos,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       pos_en,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [DW-1:0] div;
  logic [1:0]    slot;
  logic          pending;
  logic [13:0]   shadow, active;
  logic [3:0]    ax, ay, az;
  logic [1:0]    ap;
  logic          tc, fb, guard, blank_x, blank_y;
  logic [6:0]    pos_seg, digit_seg;
  assign {ax, ay, az, ap} = active;
  assign tc = div == DW'(REFRESH_DIV - 1);
  assign fb = tc & (slot == 2'd0);
  assign guard = div < DW'(GUARD);
  assign frame_start = fb;
  assign din_ready = ~pending;
  assign dp = 1'b1;
  assign blank_x = blank_lz & (ax == 4'd0);
  assign blank_y = blank_x & (ay == 4'd0);
  always_comb begin
    pos_seg = !pos_en ? 7'h7F : ap == 2'd3 ? 7'h3F : HEX[{2'b00, ap}];
    digit_seg = slot == 2'd3 ? pos_seg :
                slot == 2'd2 ? (blank_x ? 7'h7F : HEX[ax]) :
                slot == 2'd1 ? (blank_y ? 7'h7F : HEX[ay]) : HEX[az];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      slot <= 2'd3;
      pending <= 1'b0;
      shadow <= '0;
      active <= '0;
      an <= 4'hF;
      seg <= 7'h7F;
    end else begin
      div <= tc ? '0 : div + DW'(1);
      // slot 0 wraps back to 3 on the frame boundary
      if (tc) slot <= slot - 2'd1;
      an <= guard ? 4'hF : ~(4'b0001 << slot);
      seg <= guard ? 7'h7F : digit_seg;
      if (fb & pending) begin
        active <= shadow;
        pending <= 1'b0;
      end else if (din_valid & ~pending) begin
        shadow <= {din_x, din_y, din_z, din_pos};
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; stimulus queues expected {an,seg} per lit slot, monitor pops on each slot start
module tb_seg7_scan_driver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din_x = 4'd0, din_y = 4'd0, din_z = 4'd0;
  logic [1:0] din_pos = 2'd0;
  logic       din_valid = 1'b0, pos_en = 1'b1, blank_lz = 1'b0;
  logic       din_ready, dp, frame_start;
  logic [3:0] an;
  logic [6:0] seg;
  int         chk_cnt = 0, pass_cnt = 0;
  logic [10:0] exp_q [$];
  int         run = 0, fs_cnt = 0;
  logic       seen = 1'b0;
  logic [3:0] prev_an = 4'hF;
  logic [10:0] e;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4), .GUARD(1)) dut (
    .clk(clk), .reset(reset), .din_x(din_x), .din_y(din_y), .din_z(din_z), .din_pos(din_pos),
    .din_valid(din_valid), .din_ready(din_ready), .pos_en(pos_en), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  function automatic void chk(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  task automatic push_frame(input logic [6:0] e3, e2, e1, e0);
    exp_q.push_back({4'b0111, e3});
    exp_q.push_back({4'b1011, e2});
    exp_q.push_back({4'b1101, e1});
    exp_q.push_back({4'b1110, e0});
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    chk("frame_start_seen", int'(frame_start), 1);
  endtask

  task automatic offer(input logic [3:0] x, y, z, input logic [1:0] p);
    chk("ready_before_offer", int'(din_ready), 1);
    {din_x, din_y, din_z, din_pos} = {x, y, z, p};
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("ready_after_capture", int'(din_ready), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_an = 4'hF;
      run = 0;
      seen = 1'b0;
      fs_cnt = 0;
    end else begin
      fs_cnt++;
      if (frame_start) begin
        if (seen) chk("frame_period", fs_cnt, 16);
        seen = 1'b1;
        fs_cnt = 0;
      end
      if (an != 4'hF) begin
        if (prev_an == 4'hF) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL slot_unexpected: got an=%b seg=%b with nothing expected at %0t", an, seg, $time);
          end else begin
            e = exp_q.pop_front();
            chk("slot_an_seg", int'({an, seg}), int'(e));
            chk("dp_off", int'(dp), 1);
          end
        end
        run++;
      end else begin
        if (prev_an != 4'hF) chk("lit_len", run, 3);
        run = 0;
      end
      prev_an = an;
    end
  end

  initial begin
    #1 reset = 1'b0;
    #10;
    chk("rst_an", int'(an), 'hF);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_dp", int'(dp), 1);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_ready", int'(din_ready), 1);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    @(negedge clk);
    reset = 1'b1;
    wait_fs();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    repeat (4) @(negedge clk);
    offer(4'd1, 4'd2, 4'd3, 2'd1);
    {din_x, din_y, din_z, din_pos} = {4'd9, 4'd9, 4'd9, 2'd0};
    din_valid = 1'b1;
    repeat (2) @(negedge clk);
    din_valid = 1'b0;
    chk("ignored_offer_ready", int'(din_ready), 0);
    wait_fs();
    chk("ready_at_boundary", int'(din_ready), 0);
    push_frame(7'h79, 7'h79, 7'h24, 7'h30);
    @(negedge clk);
    chk("ready_after_apply", int'(din_ready), 1);
    repeat (3) @(negedge clk);
    offer(4'd0, 4'd0, 4'd0, 2'd2);
    wait_fs();
    blank_lz = 1'b1;
    push_frame(7'h24, 7'h7F, 7'h7F, 7'h40);
    repeat (4) @(negedge clk);
    offer(4'd0, 4'd5, 4'd0, 2'd2);
    wait_fs();
    push_frame(7'h24, 7'h7F, 7'h12, 7'h40);
    wait_fs();
    pos_en = 1'b0;
    blank_lz = 1'b0;
    push_frame(7'h7F, 7'h40, 7'h12, 7'h40);
    repeat (4) @(negedge clk);
    offer(4'hA, 4'hB, 4'hF, 2'd3);
    wait_fs();
    pos_en = 1'b1;
    push_frame(7'h3F, 7'h08, 7'h03, 7'h0E);
    wait_fs();
    push_frame(7'h3F, 7'h08, 7'h03, 7'h0E);
    offer(4'd7, 4'd8, 4'hC, 2'd0);
    wait_fs();
    push_frame(7'h40, 7'h78, 7'h00, 7'h46);
    repeat (4) @(negedge clk);
    offer(4'd1, 4'd1, 4'd1, 2'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_an", int'(an), 'hF);
    chk("midrst_seg", int'(seg), 'h7F);
    chk("midrst_ready", int'(din_ready), 1);
    chk("midrst_fs", int'(frame_start), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(din_ready), 1);
    wait_fs();
    push_frame(7'h40, 7'h40, 7'h40, 7'h40);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
